// File: rtl/lap_stopwatch.sv
// M:SS.t BCD stopwatch with start/stop/resume, a circular lap buffer and lap recall.
// Outputs are decoded from registers only; the lap memory is read by lap number.

module lap_stopwatch_digit #(
  parameter int MAX = 9
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       clr,
  input  logic       inc,
  output logic [3:0] q,
  output logic       carry
);
  assign carry = inc && (q == 4'(MAX));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)   q <= 4'd0;
    else if (clr) q <= 4'd0;
    else if (inc) q <= carry ? 4'd0 : q + 4'd1;
  end
endmodule

module lap_stopwatch #(
  parameter int DIV  = 5000000,
  parameter int LAPS = 4,
  parameter int IW   = $clog2(LAPS+1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start_p,
  input  logic          lap_p,
  input  logic          recall_p,
  output logic [15:0]   time_bcd,
  output logic [IW-1:0] lap_idx,
  output logic [IW-1:0] lap_cnt,
  output logic          running,
  output logic          lap_full,
  output logic          ovf
);
  localparam int DW = $clog2(DIV);
  localparam int PW = (LAPS > 1) ? $clog2(LAPS) : 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_STOP, S_RECALL} state_t;

  state_t           st, nxt;
  logic [DW-1:0]    div;
  logic [3:0][3:0]  dig;
  logic [4:0]       inc_c;
  logic [PW-1:0]    wr_ptr, rd_pos;
  logic [IW-1:0]    rd_idx;
  logic [15:0]      lap_mem [LAPS];
  logic             count_en, tick, do_lap, do_rec, capture, clr_all;
  int               pos_i;

  // start_p outranks lap_p, which outranks recall_p
  assign do_lap   = lap_p & ~start_p;
  assign do_rec   = recall_p & ~start_p & ~lap_p;
  assign count_en = (st == S_RUN) & ~start_p;
  assign tick     = count_en & (div == DW'(DIV-1));
  assign capture  = (st == S_RUN) & do_lap;
  assign clr_all  = (st == S_STOP) & do_lap;

  always_comb begin
    nxt = st;
    case (st)
      S_IDLE:   if (start_p) nxt = S_RUN;
      S_RUN:    if (start_p) nxt = S_STOP;
      S_STOP: begin
        if (start_p)                       nxt = S_RUN;
        else if (lap_p)                    nxt = S_IDLE;
        else if (recall_p && lap_cnt != 0) nxt = S_RECALL;
      end
      S_RECALL: if (start_p) nxt = S_STOP;
      default:  nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) st <= S_IDLE;
    else        st <= nxt;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)        div <= '0;
    else if (clr_all)  div <= '0;
    else if (count_en) div <= (div == DW'(DIV-1)) ? '0 : div + DW'(1);
  end

  assign inc_c[0] = tick;
  for (genvar i = 0; i < 4; i++) begin : g_dig
    localparam int MAX = (i == 2) ? 5 : 9;
    lap_stopwatch_digit #(.MAX(MAX)) u_dig (
      .clk   (clk),
      .reset (reset),
      .clr   (clr_all),
      .inc   (inc_c[i]),
      .q     (dig[i]),
      .carry (inc_c[i+1])
    );
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)        ovf <= 1'b0;
    else if (clr_all)  ovf <= 1'b0;
    else if (inc_c[4]) ovf <= 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr  <= '0;
      lap_cnt <= '0;
    end else if (clr_all) begin
      wr_ptr  <= '0;
      lap_cnt <= '0;
    end else if (capture) begin
      wr_ptr <= (wr_ptr == PW'(LAPS-1)) ? '0 : wr_ptr + PW'(1);
      if (!lap_full) lap_cnt <= lap_cnt + IW'(1);
    end
  end

  // capture stores the value shown before this edge's tick
  always_ff @(posedge clk) begin
    if (capture) lap_mem[wr_ptr] <= dig;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      rd_idx <= '0;
    else if (st == S_STOP && nxt == S_RECALL)
      rd_idx <= lap_cnt;
    else if (st == S_RECALL && do_rec)
      rd_idx <= (rd_idx == IW'(1)) ? lap_cnt : rd_idx - IW'(1);
  end

  // lap number 1 is the oldest; once full, the oldest sits at the write pointer
  always_comb begin
    pos_i = int'(rd_idx) - 1 + (lap_full ? int'(wr_ptr) : 0);
    if (pos_i < 0)     pos_i = 0;
    if (pos_i >= LAPS) pos_i = pos_i - LAPS;
    rd_pos = PW'(pos_i);
  end

  assign running  = (st == S_RUN);
  assign lap_full = (lap_cnt == IW'(LAPS));
  assign lap_idx  = (st == S_RECALL) ? rd_idx : '0;
  assign time_bcd = (st == S_RECALL) ? lap_mem[rd_pos] : dig;
endmodule

// File: tb/tb_lap_stopwatch.sv
// Bench for lap_stopwatch: directed scenarios plus random pulses, all checked
// against a model that keeps elapsed time as a plain cycle count and laps in a queue.

module tb_lap_stopwatch;
  localparam int DIV  = 4;
  localparam int LAPS = 4;
  localparam int IW   = $clog2(LAPS+1);

  logic          clk = 1'b0;
  logic          reset, start_p, lap_p, recall_p;
  logic [15:0]   time_bcd;
  logic [IW-1:0] lap_idx, lap_cnt;
  logic          running, lap_full, ovf;

  int n_tests = 0;
  int n_fail  = 0;

  // model: 0 idle, 1 run, 2 stop, 3 recall
  int          m_mode;
  int          m_c;
  bit          m_ovf;
  int          m_idx;
  logic [15:0] m_q[$];

  lap_stopwatch #(.DIV(DIV), .LAPS(LAPS)) dut (
    .clk      (clk),
    .reset    (reset),
    .start_p  (start_p),
    .lap_p    (lap_p),
    .recall_p (recall_p),
    .time_bcd (time_bcd),
    .lap_idx  (lap_idx),
    .lap_cnt  (lap_cnt),
    .running  (running),
    .lap_full (lap_full),
    .ovf      (ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [15:0] to_bcd(input int t);
    int s;
    s = (t / 10) % 60;
    return {4'(t / 600), 4'(s / 10), 4'(s % 10), 4'(t % 10)};
  endfunction

  function automatic logic [15:0] m_live();
    return to_bcd((m_c / DIV) % 6000);
  endfunction

  task automatic model_reset();
    m_mode = 0; m_c = 0; m_ovf = 0; m_idx = 0;
    m_q.delete();
  endtask

  task automatic model_edge(input bit s, input bit l, input bit r);
    logic [15:0] pre;
    int mode0;
    pre   = m_live();
    mode0 = m_mode;
    if (s) begin
      m_mode = (mode0 == 0 || mode0 == 2) ? 1 : 2;
      m_idx  = 0;
    end else if (l) begin
      if (mode0 == 1) begin
        m_q.push_back(pre);
        if (m_q.size() > LAPS) void'(m_q.pop_front());
      end else if (mode0 == 2) begin
        m_c = 0; m_ovf = 0; m_mode = 0;
        m_q.delete();
      end
    end else if (r) begin
      if (mode0 == 2 && m_q.size() > 0) begin
        m_mode = 3; m_idx = m_q.size();
      end else if (mode0 == 3) begin
        m_idx = (m_idx == 1) ? m_q.size() : m_idx - 1;
      end
    end
    if (mode0 == 1 && !s) begin
      m_c++;
      if (m_c / DIV >= 6000) m_ovf = 1;
    end
  endtask

  task automatic check_all();
    logic [15:0] e_time;
    e_time = (m_mode == 3) ? m_q[m_idx-1] : m_live();
    chk("time_bcd", 32'(time_bcd), 32'(e_time));
    chk("lap_idx",  32'(lap_idx),  32'((m_mode == 3) ? m_idx : 0));
    chk("lap_cnt",  32'(lap_cnt),  32'(m_q.size()));
    chk("running",  32'(running),  32'(m_mode == 1));
    chk("lap_full", 32'(lap_full), 32'(m_q.size() == LAPS));
    chk("ovf",      32'(ovf),      32'(m_ovf));
  endtask

  // one clock: drive pulses at negedge, update model at the edge, check at next negedge
  task automatic cyc(input bit s, input bit l, input bit r, input bit do_chk = 1'b1);
    start_p = s; lap_p = l; recall_p = r;
    @(posedge clk);
    model_edge(s, l, r);
    @(negedge clk);
    start_p = 1'b0; lap_p = 1'b0; recall_p = 1'b0;
    if (do_chk) check_all();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0);
  endtask

  task automatic run_until(input int target);
    for (int i = 0; i < 1000 && m_c < target; i++) cyc(0, 0, 0);
    chk("run_until", 32'(m_c), 32'(target));
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, ".time"},    32'(time_bcd), 32'h0);
    chk({tag, ".idx"},     32'(lap_idx),  32'h0);
    chk({tag, ".cnt"},     32'(lap_cnt),  32'h0);
    chk({tag, ".running"}, 32'(running),  32'h0);
    chk({tag, ".full"},    32'(lap_full), 32'h0);
    chk({tag, ".ovf"},     32'(ovf),      32'h0);
  endtask

  initial begin
    reset = 1'b0; start_p = 1'b0; lap_p = 1'b0; recall_p = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    chk_reset_outs("reset");
    reset = 1'b1;
    idle(3);

    // basic run and hold
    cyc(1, 0, 0);
    idle(40);
    cyc(1, 0, 0);
    chk("basic.time", 32'(time_bcd), 32'h0010);
    idle(20);
    chk("basic.hold", 32'(time_bcd), 32'h0010);

    // resume without lost or extra tick
    cyc(1, 0, 0);
    idle(8);
    cyc(1, 0, 0);
    chk("resume.time", 32'(time_bcd), 32'h0012);

    // clear, then five laps with overwrite
    cyc(0, 1, 0);
    chk("clear.cnt", 32'(lap_cnt), 32'h0);
    cyc(1, 0, 0);
    run_until(13); cyc(0, 1, 0);
    run_until(21); cyc(0, 1, 0);
    run_until(37); cyc(0, 1, 0);
    run_until(49); cyc(0, 1, 0);
    run_until(65); cyc(0, 1, 0);
    cyc(1, 0, 0);
    chk("laps.cnt",  32'(lap_cnt),  32'h4);
    chk("laps.full", 32'(lap_full), 32'h1);
    cyc(0, 0, 1); chk("rc1.time", 32'(time_bcd), 32'h0016); chk("rc1.idx", 32'(lap_idx), 32'h4);
    cyc(0, 0, 1); chk("rc2.time", 32'(time_bcd), 32'h0012); chk("rc2.idx", 32'(lap_idx), 32'h3);
    cyc(0, 0, 1); chk("rc3.time", 32'(time_bcd), 32'h0009); chk("rc3.idx", 32'(lap_idx), 32'h2);
    cyc(0, 0, 1); chk("rc4.time", 32'(time_bcd), 32'h0005); chk("rc4.idx", 32'(lap_idx), 32'h1);
    cyc(0, 0, 1); chk("rc5.time", 32'(time_bcd), 32'h0016); chk("rc5.idx", 32'(lap_idx), 32'h4);
    cyc(0, 1, 0);
    chk("rc.lap_ignored", 32'(lap_cnt), 32'h4);
    cyc(1, 0, 0);
    chk("rc.exit_idx", 32'(lap_idx), 32'h0);

    // start and lap together: stop wins, nothing stored
    cyc(0, 1, 0);
    cyc(1, 0, 0);
    idle(7);
    cyc(1, 1, 0);
    chk("sim.running", 32'(running), 32'h0);
    chk("sim.cnt",     32'(lap_cnt), 32'h0);

    // lap coincident with tick
    cyc(0, 1, 0);
    cyc(1, 0, 0);
    run_until(15);
    cyc(0, 1, 0);
    chk("coinc.live", 32'(time_bcd), 32'h0004);
    cyc(1, 0, 0);
    cyc(0, 0, 1);
    chk("coinc.lap", 32'(time_bcd), 32'h0003);
    cyc(1, 0, 0);

    // wrap past 9:59.9
    cyc(0, 1, 0);
    cyc(1, 0, 0);
    for (int i = 0; i < 6000*DIV; i++) cyc(0, 0, 0, (i % 500) == 0);
    check_all();
    chk("wrap.time", 32'(time_bcd), 32'h0000);
    chk("wrap.ovf",  32'(ovf),      32'h1);
    cyc(1, 0, 0);
    cyc(0, 1, 0);
    chk("wclr.ovf",     32'(ovf),     32'h0);
    chk("wclr.cnt",     32'(lap_cnt), 32'h0);
    chk("wclr.running", 32'(running), 32'h0);
    cyc(0, 0, 1);
    chk("wclr.recall", 32'(lap_idx), 32'h0);

    // random pulses
    for (int i = 0; i < 3000; i++)
      cyc(($urandom % 9) == 0, ($urandom % 7) == 0, ($urandom % 5) == 0);

    // async reset mid-recall, between edges
    cyc(1, 0, 0);
    if (m_mode != 2) cyc(1, 0, 0);
    if (m_mode == 2) cyc(0, 1, 0);
    cyc(1, 0, 0);
    idle(10);
    cyc(0, 1, 0);
    idle(5);
    cyc(1, 0, 0);
    cyc(0, 0, 1);
    chk("pre_rst.idx", 32'(lap_idx), 32'h1);
    @(posedge clk);
    #2 reset = 1'b0;
    #1;
    model_reset();
    chk_reset_outs("async_rst");
    @(negedge clk);
    reset = 1'b1;
    idle(4);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
